audio_rd_arb: RTL and testbench
===============================

Name: audio_rd_arb

Overview:
- Two-source AXI4 read-channel arbiter.
- Shares the single SoC DMA read master port between the audio formatter MM2S master (source 0) and a second read requester (source 1, e.g. a future capture/mixer engine).
- Tags each request with its source in the ID MSB, routes R beats back by that bit, and caps outstanding bursts per source.
- Read channels only; the AW/W/B tie-off stays outside this block.

Parameters:
- ID_W, 4, slave-side ID width; master ID width is ID_W+1.
- MAX_OUT, 4, maximum outstanding bursts per source (1..15).

Ports:
- aclk  input  1  system clock.
- aresetn  input  1  asynchronous active-low reset.
- s{0,1}_ar_addr  input  32  read address.
- s{0,1}_ar_len  input  8  burst length.
- s{0,1}_ar_size  input  3  beat size.
- s{0,1}_ar_burst  input  2  burst type.
- s{0,1}_ar_id  input  ID_W  request ID.
- s{0,1}_ar_valid  input  1  request valid.
- s{0,1}_ar_ready  output  1  request accepted.
- s{0,1}_r_data  output  32  read data.
- s{0,1}_r_resp  output  2  response.
- s{0,1}_r_id  output  ID_W  response ID.
- s{0,1}_r_last  output  1  last beat.
- s{0,1}_r_valid  output  1  beat valid.
- s{0,1}_r_ready  input  1  beat accepted.
- m_ar_addr/len/size/burst  output  32/8/3/2  forwarded request.
- m_ar_id  output  ID_W+1  {source, s_ar_id}.
- m_ar_prot  output  3  constant AR_PROT_DEF.
- m_ar_cache  output  4  constant AR_CACHE_DEF.
- m_ar_valid  output  1  request valid.
- m_ar_ready  input  1  request accepted.
- m_r_data/resp/id/last/valid  input  32/2/ID_W+1/1/1  returned beat.
- m_r_ready  output  1  beat accepted.

Behaviour:
- Reset (async, aresetn low):
  - state IDLE, m_ar_valid=0, m_ar_addr/len/size/burst/id=0.
  - s*_ar_ready=0, both outstanding counters=0, RR pointer=0 (s0 preferred).
  - Reset mid-burst discards all tracking; no R recovery is attempted.
- Eligibility: source i is eligible when s_i_ar_valid && cnt_i < MAX_OUT.
- IDLE:
  - If no source is eligible, remain in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the RR-pointer source.
  - Grant cycle: s_i_ar_ready=1 for exactly one cycle (combinational from state and eligibility).
  - The request is captured into the output register; next state is ISSUE.
- ISSUE:
  - m_ar_valid=1; fields are held stable until m_ar_ready.
  - On handshake: return to IDLE and set the RR pointer to the non-granted source.
  - s*_ar_ready=0 throughout ISSUE.
  - Latency from s AR handshake to m_ar_valid is 1 cycle; peak throughput is 1 AR per 2 cycles.
- ID tagging: m_ar_id = {i[0], s_i_ar_id}.
- R routing (combinational):
  - sel = m_r_id[ID_W].
  - s_sel_r_* = m_r_* with r_id = m_r_id[ID_W-1:0].
  - m_r_ready = s_sel_r_ready.
  - The non-selected s_r_valid=0.
- Counters (width $clog2(MAX_OUT+1)):
  - Increment on the s_i AR handshake.
  - Decrement on m_r_valid && m_r_ready && m_r_last && sel==i.
  - Simultaneous increment and decrement leaves the counter unchanged.
  - A counter at 0 receiving a stray last stays 0 (no underflow).
  - A source at MAX_OUT sees ar_ready held 0 until a last beat returns.
- R beats never stall the AR path, and AR never stalls R.

Optional Feature:
- Macro AUDIO_RD_ARB_FIXED_PRIO_EN.
- Defined: source 0 (audio) always wins when both sources are eligible; the RR pointer is unused, so source 1 may starve.
- Undefined: round-robin as described above.

Decomposition:
- Package audio_rd_arb_pkg holds:
  - ar_req_t struct (addr, len, size, burst, id);
  - AR_PROT_DEF=3'b000 and AR_CACHE_DEF=4'b0011;
  - arb state enum {IDLE, ISSUE}.
- Sub-module rd_out_cnt (parameter MAX_OUT; inputs inc, dec; outputs full, cnt), instantiated once per source.

Test Plan:
- s0 only: addr 0x1000_0000, len 7, id 2; m_ar_ready tied 1 -> m_ar_valid 1 cycle after the s0 handshake; m_ar_id=5'b0_0010; 8 R beats route to s0 with r_id=2; cnt0 returns to 0.
- Both sources valid continuously, 6 requests each -> grants alternate s0,s1,s0,...; with AUDIO_RD_ARB_FIXED_PRIO_EN, all 6 s0 requests are granted before any s1 request.
- MAX_OUT=4, s1 issues 5 requests, no R returned -> the 5th request sees s1_ar_ready held 0; one r_last to s1 -> the 5th is accepted the next IDLE cycle.
- m_ar_ready held 0 for 10 cycles -> m_ar_* fields stable, s*_ar_ready 0; both sources resume after release.
- Interleaved R beats (s0 id 1 beat, s1 id 3 beat, alternating) with s0_r_ready=0 for 3 cycles -> m_r_ready follows the selected source, no beat is lost or misrouted, and the AR issued in the same cycle as a last beat leaves the counter unchanged.
- aresetn asserted while in ISSUE with cnt0=2 -> m_ar_valid=0 immediately, counters 0, state IDLE after release.

Source files
------------

// File: rtl/audio_rd_arb_pkg.sv
// audio_rd_arb_pkg: shared types and constants for the two-source AXI4 read arbiter.
package audio_rd_arb_pkg;

  // Widest tagged ID the request record can carry ({source, slave id}).
  localparam int unsigned AR_ID_MAX_W = 16;

  localparam logic [2:0] AR_PROT_DEF  = 3'b000;
  localparam logic [3:0] AR_CACHE_DEF = 4'b0011;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [31:0]            addr;
    logic [7:0]             len;
    logic [2:0]             size;
    logic [1:0]             burst;
    logic [AR_ID_MAX_W-1:0] id;
  } ar_req_t;

endpackage

// File: rtl/audio_rd_arb_out_cnt.sv
// rd_out_cnt: outstanding-burst counter for one read source; saturates at 0 and MAX_OUT.
module rd_out_cnt
  import audio_rd_arb_pkg::*;
#(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           inc,
  input  logic                           dec,
  output logic                           full,
  output logic [$clog2(MAX_OUT+1)-1:0]   cnt
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  assign full = (cnt == CW'(MAX_OUT));

  // Simultaneous inc/dec holds; a stray last at zero is ignored.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (inc && !dec && !full) begin
      cnt <= cnt + CW'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/audio_rd_arb.sv
// audio_rd_arb: two-source AXI4 read-channel arbiter onto one master port.
// Requests are tagged with the source in the ID MSB; R beats route back on that bit.
// Build option: AUDIO_RD_ARB_FIXED_PRIO_EN gives source 0 strict priority (no round-robin).
module audio_rd_arb
  import audio_rd_arb_pkg::*;
#(
  parameter int unsigned ID_W    = 4,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic            aclk,
  input  logic            aresetn,
  // source 0
  input  logic [31:0]     s0_ar_addr,
  input  logic [7:0]      s0_ar_len,
  input  logic [2:0]      s0_ar_size,
  input  logic [1:0]      s0_ar_burst,
  input  logic [ID_W-1:0] s0_ar_id,
  input  logic            s0_ar_valid,
  output logic            s0_ar_ready,
  output logic [31:0]     s0_r_data,
  output logic [1:0]      s0_r_resp,
  output logic [ID_W-1:0] s0_r_id,
  output logic            s0_r_last,
  output logic            s0_r_valid,
  input  logic            s0_r_ready,
  // source 1
  input  logic [31:0]     s1_ar_addr,
  input  logic [7:0]      s1_ar_len,
  input  logic [2:0]      s1_ar_size,
  input  logic [1:0]      s1_ar_burst,
  input  logic [ID_W-1:0] s1_ar_id,
  input  logic            s1_ar_valid,
  output logic            s1_ar_ready,
  output logic [31:0]     s1_r_data,
  output logic [1:0]      s1_r_resp,
  output logic [ID_W-1:0] s1_r_id,
  output logic            s1_r_last,
  output logic            s1_r_valid,
  input  logic            s1_r_ready,
  // master
  output logic [31:0]     m_ar_addr,
  output logic [7:0]      m_ar_len,
  output logic [2:0]      m_ar_size,
  output logic [1:0]      m_ar_burst,
  output logic [ID_W:0]   m_ar_id,
  output logic [2:0]      m_ar_prot,
  output logic [3:0]      m_ar_cache,
  output logic            m_ar_valid,
  input  logic            m_ar_ready,
  input  logic [31:0]     m_r_data,
  input  logic [1:0]      m_r_resp,
  input  logic [ID_W:0]   m_r_id,
  input  logic            m_r_last,
  input  logic            m_r_valid,
  output logic            m_r_ready
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  arb_state_t state_q;
  ar_req_t    req_q;
  ar_req_t    req_d;

  logic full0, full1;
  logic elig0, elig1;
  logic pick0;
  logic grant0, grant1;
  logic idle;
  logic sel;
  logic dec0, dec1;
  logic [CW-1:0] cnt0_unused, cnt1_unused;
  logic          id_hi_unused;

  assign elig0 = s0_ar_valid && !full0;
  assign elig1 = s1_ar_valid && !full1;

`ifdef AUDIO_RD_ARB_FIXED_PRIO_EN
  assign pick0 = 1'b1;
`else
  logic rr_q;

  assign pick0 = ~rr_q;

  // Round-robin pointer moves to the other source after each master handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rr_q <= 1'b0;
    end else if ((state_q == ISSUE) && m_ar_ready) begin
      rr_q <= ~req_q.id[ID_W];
    end
  end
`endif

  // Reset gates the combinational grant so ar_ready stays low while aresetn is low.
  assign idle   = aresetn && (state_q == IDLE);
  assign grant0 = idle && elig0 && (!elig1 || pick0);
  assign grant1 = idle && elig1 && (!elig0 || !pick0);

  assign s0_ar_ready = grant0;
  assign s1_ar_ready = grant1;

  // Select the granted request and tag its ID with the source bit.
  always_comb begin
    req_d = '0;
    if (grant1) begin
      req_d.addr  = s1_ar_addr;
      req_d.len   = s1_ar_len;
      req_d.size  = s1_ar_size;
      req_d.burst = s1_ar_burst;
      req_d.id    = AR_ID_MAX_W'({1'b1, s1_ar_id});
    end else begin
      req_d.addr  = s0_ar_addr;
      req_d.len   = s0_ar_len;
      req_d.size  = s0_ar_size;
      req_d.burst = s0_ar_burst;
      req_d.id    = AR_ID_MAX_W'({1'b0, s0_ar_id});
    end
  end

  // Arbitration FSM: capture on grant, hold the AR until the master accepts it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      req_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            req_q   <= req_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_ar_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_ar_addr  = req_q.addr;
  assign m_ar_len   = req_q.len;
  assign m_ar_size  = req_q.size;
  assign m_ar_burst = req_q.burst;
  assign m_ar_id    = req_q.id[ID_W:0];
  assign m_ar_prot  = AR_PROT_DEF;
  assign m_ar_cache = AR_CACHE_DEF;
  assign m_ar_valid = (state_q == ISSUE);

  // Upper record ID bits are always zero for this ID_W.
  assign id_hi_unused = ^req_q.id;

  assign sel = m_r_id[ID_W];

  assign s0_r_data  = m_r_data;
  assign s0_r_resp  = m_r_resp;
  assign s0_r_id    = m_r_id[ID_W-1:0];
  assign s0_r_last  = m_r_last;
  assign s0_r_valid = m_r_valid && !sel;

  assign s1_r_data  = m_r_data;
  assign s1_r_resp  = m_r_resp;
  assign s1_r_id    = m_r_id[ID_W-1:0];
  assign s1_r_last  = m_r_last;
  assign s1_r_valid = m_r_valid && sel;

  assign m_r_ready = sel ? s1_r_ready : s0_r_ready;

  assign dec0 = m_r_valid && m_r_ready && m_r_last && !sel;
  assign dec1 = m_r_valid && m_r_ready && m_r_last && sel;

  rd_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt0 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (grant0),
    .dec     (dec0),
    .full    (full0),
    .cnt     (cnt0_unused)
  );

  rd_out_cnt #(.MAX_OUT(MAX_OUT)) u_cnt1 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .inc     (grant1),
    .dec     (dec1),
    .full    (full1),
    .cnt     (cnt1_unused)
  );

endmodule

// File: tb/tb_audio_rd_arb.sv
// tb_audio_rd_arb: directed self-checking bench for audio_rd_arb (ID_W=4, MAX_OUT=4).
module tb_audio_rd_arb;
  import audio_rd_arb_pkg::*;

  localparam int unsigned ID_W    = 4;
  localparam int unsigned MAX_OUT = 4;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [31:0]     s0_ar_addr = '0, s1_ar_addr = '0;
  logic [7:0]      s0_ar_len = '0, s1_ar_len = '0;
  logic [2:0]      s0_ar_size = '0, s1_ar_size = '0;
  logic [1:0]      s0_ar_burst = '0, s1_ar_burst = '0;
  logic [ID_W-1:0] s0_ar_id = '0, s1_ar_id = '0;
  logic            s0_ar_valid = 1'b0, s1_ar_valid = 1'b0;
  logic            s0_ar_ready, s1_ar_ready;
  logic [31:0]     s0_r_data, s1_r_data;
  logic [1:0]      s0_r_resp, s1_r_resp;
  logic [ID_W-1:0] s0_r_id, s1_r_id;
  logic            s0_r_last, s1_r_last;
  logic            s0_r_valid, s1_r_valid;
  logic            s0_r_ready = 1'b1, s1_r_ready = 1'b1;
  logic [31:0]     m_ar_addr;
  logic [7:0]      m_ar_len;
  logic [2:0]      m_ar_size;
  logic [1:0]      m_ar_burst;
  logic [ID_W:0]   m_ar_id;
  logic [2:0]      m_ar_prot;
  logic [3:0]      m_ar_cache;
  logic            m_ar_valid;
  logic            m_ar_ready = 1'b1;
  logic [31:0]     m_r_data = '0;
  logic [1:0]      m_r_resp = '0;
  logic [ID_W:0]   m_r_id = '0;
  logic            m_r_last = 1'b0;
  logic            m_r_valid = 1'b0;
  logic            m_r_ready;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [4:0]  bid  [4] = '{5'h01, 5'h13, 5'h01, 5'h13};
  logic [31:0] bdat [4] = '{32'hA000_0000, 32'hB000_0001, 32'hA000_0002, 32'hB000_0003};
  logic        blast[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  always #5 aclk = ~aclk;

  audio_rd_arb #(.ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s0_ar_addr(s0_ar_addr), .s0_ar_len(s0_ar_len), .s0_ar_size(s0_ar_size),
    .s0_ar_burst(s0_ar_burst), .s0_ar_id(s0_ar_id), .s0_ar_valid(s0_ar_valid),
    .s0_ar_ready(s0_ar_ready), .s0_r_data(s0_r_data), .s0_r_resp(s0_r_resp),
    .s0_r_id(s0_r_id), .s0_r_last(s0_r_last), .s0_r_valid(s0_r_valid), .s0_r_ready(s0_r_ready),
    .s1_ar_addr(s1_ar_addr), .s1_ar_len(s1_ar_len), .s1_ar_size(s1_ar_size),
    .s1_ar_burst(s1_ar_burst), .s1_ar_id(s1_ar_id), .s1_ar_valid(s1_ar_valid),
    .s1_ar_ready(s1_ar_ready), .s1_r_data(s1_r_data), .s1_r_resp(s1_r_resp),
    .s1_r_id(s1_r_id), .s1_r_last(s1_r_last), .s1_r_valid(s1_r_valid), .s1_r_ready(s1_r_ready),
    .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size), .m_ar_burst(m_ar_burst),
    .m_ar_id(m_ar_id), .m_ar_prot(m_ar_prot), .m_ar_cache(m_ar_cache),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_id(m_r_id), .m_r_last(m_r_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   rem0, rem1, grants, cyc, stall, exp_src;
    int   order[$];
    logic hs, sel;

    // ---------------- reset state ----------------
    s0_ar_valid = 1'b1;
    step();
    chk("rst_s0_ready", s0_ar_ready, 0);
    chk("rst_m_valid", m_ar_valid, 0);
    chk("rst_m_addr", m_ar_addr, 0);
    chk("rst_m_id", m_ar_id, 0);
    chk("rst_cnt0", dut.u_cnt0.cnt, 0);
    chk("rst_state", dut.state_q, IDLE);
    s0_ar_valid = 1'b0;
    aresetn = 1'b1;
    step();

    // ---------------- s0 single burst ----------------
    m_ar_ready  = 1'b1;
    s0_ar_addr  = 32'h1000_0000;
    s0_ar_len   = 8'd7;
    s0_ar_size  = 3'd2;
    s0_ar_burst = 2'd1;
    s0_ar_id    = 4'd2;
    s0_ar_valid = 1'b1;
    #1;
    chk("t1_s0_ready", s0_ar_ready, 1);
    chk("t1_s1_ready", s1_ar_ready, 0);
    step();
    s0_ar_valid = 1'b0;
    chk("t1_m_valid", m_ar_valid, 1);
    chk("t1_m_addr", m_ar_addr, 32'h1000_0000);
    chk("t1_m_len", m_ar_len, 7);
    chk("t1_m_size", m_ar_size, 2);
    chk("t1_m_burst", m_ar_burst, 1);
    chk("t1_m_id", m_ar_id, 5'b0_0010);
    chk("t1_m_prot", m_ar_prot, 3'b000);
    chk("t1_m_cache", m_ar_cache, 4'b0011);
    chk("t1_s0_ready_issue", s0_ar_ready, 0);
    step();
    chk("t1_m_valid_done", m_ar_valid, 0);
    chk("t1_cnt0_one", dut.u_cnt0.cnt, 1);
    for (int i = 0; i < 8; i++) begin
      m_r_valid = 1'b1;
      m_r_id    = 5'b0_0010;
      m_r_data  = 32'hD000_0000 + i;
      m_r_resp  = 2'b00;
      m_r_last  = (i == 7);
      #1;
      chk("t1_r_s0_valid", s0_r_valid, 1);
      chk("t1_r_s1_valid", s1_r_valid, 0);
      chk("t1_r_data", s0_r_data, 32'hD000_0000 + i);
      chk("t1_r_id", s0_r_id, 2);
      chk("t1_r_last", s0_r_last, (i == 7));
      chk("t1_m_r_ready", m_r_ready, 1);
      step();
    end
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
    chk("t1_cnt0_zero", dut.u_cnt0.cnt, 0);

    // ---------------- both sources, 6 requests each ----------------
    do_reset();
    s0_ar_id = 4'd1;
    s1_ar_id = 4'd3;
    rem0 = 6;
    rem1 = 6;
    cyc  = 0;
    while ((rem0 > 0 || rem1 > 0 || m_ar_valid) && cyc < 60) begin
      s0_ar_valid = (rem0 > 0);
      s1_ar_valid = (rem1 > 0);
      m_r_valid   = m_ar_valid;
      m_r_id      = m_ar_id;
      m_r_last    = 1'b1;
      #1;
      chk("t2_exclusive", s0_ar_ready & s1_ar_ready, 0);
      if (s0_ar_ready) begin order.push_back(0); rem0--; end
      if (s1_ar_ready) begin order.push_back(1); rem1--; end
      step();
      cyc++;
    end
    s0_ar_valid = 1'b0;
    s1_ar_valid = 1'b0;
    m_r_valid   = 1'b0;
    m_r_last    = 1'b0;
    chk("t2_grant_count", order.size(), 12);
    for (int k = 0; k < order.size(); k++) begin
`ifdef AUDIO_RD_ARB_FIXED_PRIO_EN
      exp_src = (k < 6) ? 0 : 1;
`else
      exp_src = k % 2;
`endif
      chk("t2_order", order[k], exp_src);
    end
    chk("t2_cnt0", dut.u_cnt0.cnt, 0);
    chk("t2_cnt1", dut.u_cnt1.cnt, 0);

    // ---------------- MAX_OUT cap on s1 ----------------
    do_reset();
    m_ar_ready  = 1'b1;
    s1_ar_addr  = 32'h2000_0000;
    s1_ar_id    = 4'd3;
    s1_ar_valid = 1'b1;
    grants = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (s1_ar_ready) grants++;
      step();
    end
    chk("t3_grants", grants, MAX_OUT);
    chk("t3_cnt1_full", dut.u_cnt1.cnt, MAX_OUT);
    chk("t3_ready_held", s1_ar_ready, 0);
    m_r_valid = 1'b1;
    m_r_id    = 5'b1_0011;
    m_r_last  = 1'b1;
    #1;
    chk("t3_ready_before_last", s1_ar_ready, 0);
    chk("t3_r_s1_valid", s1_r_valid, 1);
    step();
    m_r_valid = 1'b0;
    m_r_last  = 1'b0;
    #1;
    chk("t3_ready_after_last", s1_ar_ready, 1);
    chk("t3_cnt1_dec", dut.u_cnt1.cnt, MAX_OUT - 1);
    step();
    s1_ar_valid = 1'b0;
    chk("t3_cnt1_refull", dut.u_cnt1.cnt, MAX_OUT);
    chk("t3_m_valid", m_ar_valid, 1);
    step();

    // ---------------- master AR backpressure ----------------
    do_reset();
    m_ar_ready  = 1'b0;
    s0_ar_addr  = 32'h3000_0040;
    s0_ar_len   = 8'd3;
    s0_ar_id    = 4'd1;
    s0_ar_valid = 1'b1;
    s1_ar_addr  = 32'h4000_0080;
    s1_ar_len   = 8'd1;
    s1_ar_id    = 4'd3;
    s1_ar_valid = 1'b1;
    #1;
    chk("t4_s0_grant", s0_ar_ready, 1);
    chk("t4_s1_wait", s1_ar_ready, 0);
    step();
    s0_ar_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("t4_hold_valid", m_ar_valid, 1);
      chk("t4_hold_addr", m_ar_addr, 32'h3000_0040);
      chk("t4_hold_id", m_ar_id, 5'h01);
      chk("t4_hold_len", m_ar_len, 3);
      chk("t4_hold_s0_ready", s0_ar_ready, 0);
      chk("t4_hold_s1_ready", s1_ar_ready, 0);
      step();
    end
    m_ar_ready = 1'b1;
    step();
    chk("t4_s1_resume", s1_ar_ready, 1);
    step();
    s1_ar_valid = 1'b0;
    chk("t4_s1_issue", m_ar_valid, 1);
    chk("t4_s1_addr", m_ar_addr, 32'h4000_0080);
    chk("t4_s1_id", m_ar_id, 5'h13);
    step();
    chk("t4_idle", m_ar_valid, 0);
    s0_ar_valid = 1'b1;
    #1;
    chk("t4_s0_resume", s0_ar_ready, 1);
    step();
    s0_ar_valid = 1'b0;
    step();
    chk("t4_cnt0", dut.u_cnt0.cnt, 2);
    chk("t4_cnt1", dut.u_cnt1.cnt, 1);

    // ---------------- interleaved R with s0 stall ----------------
    stall = 3;
    for (int b = 0; b < 4; b++) begin
      hs = 1'b0;
      for (int c = 0; c < 10 && !hs; c++) begin
        m_r_valid   = 1'b1;
        m_r_id      = bid[b];
        m_r_data    = bdat[b];
        m_r_last    = blast[b];
        m_r_resp    = 2'b00;
        s0_r_ready  = (stall == 0);
        s1_r_ready  = 1'b1;
        s0_ar_valid = (b == 2);
        #1;
        sel = bid[b][4];
        chk("t5_s0_valid", s0_r_valid, !sel);
        chk("t5_s1_valid", s1_r_valid, sel);
        chk("t5_data", sel ? s1_r_data : s0_r_data, bdat[b]);
        chk("t5_id", sel ? s1_r_id : s0_r_id, bid[b][3:0]);
        chk("t5_m_r_ready", m_r_ready, sel ? 1'b1 : (stall == 0));
        if (b == 2) chk("t5_ar_with_last", s0_ar_ready, 1);
        hs = sel || (stall == 0);
        step();
        if (stall > 0) stall--;
      end
      chk("t5_beat_taken", hs, 1);
      if (b == 2) begin
        s0_ar_valid = 1'b0;
        chk("t5_cnt0_unchanged", dut.u_cnt0.cnt, 2);
      end
    end
    m_r_valid  = 1'b0;
    m_r_last   = 1'b0;
    s0_r_ready = 1'b1;
    chk("t5_cnt1_zero", dut.u_cnt1.cnt, 0);
    chk("t5_cnt0_final", dut.u_cnt0.cnt, 2);
    chk("t5_m_ar_done", m_ar_valid, 0);

    // ---------------- reset while in ISSUE ----------------
    do_reset();
    m_ar_ready  = 1'b1;
    s0_ar_addr  = 32'h5000_0000;
    s0_ar_id    = 4'd2;
    s0_ar_valid = 1'b1;
    step();
    step();
    m_ar_ready = 1'b0;
    step();
    s0_ar_valid = 1'b0;
    chk("t6_in_issue", m_ar_valid, 1);
    chk("t6_cnt0_two", dut.u_cnt0.cnt, 2);
    chk("t6_state_issue", dut.state_q, ISSUE);
    #3;
    aresetn = 1'b0;
    #1;
    chk("t6_async_valid", m_ar_valid, 0);
    chk("t6_async_cnt0", dut.u_cnt0.cnt, 0);
    chk("t6_async_addr", m_ar_addr, 0);
    step();
    aresetn = 1'b1;
    step();
    chk("t6_state_idle", dut.state_q, IDLE);
    chk("t6_valid_after", m_ar_valid, 0);
    chk("t6_cnt0_after", dut.u_cnt0.cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
